clk_rx_monitor: RTL and testbench
=================================

Name: clk_rx_monitor

Overview:
- Receive-side checker for one distributed clock output of the clock distributor.
- Samples the delivered clock as asynchronous data in the ref_clk domain and measures its period and high time in ref_clk cycles.
- Checks the measurement against the programmed divide ratio, runs a lock/fault state machine, and reports valid, stable and error status back to the RCD status/CSR logic.

Parameters:
CNT_W, 8, width of the period and high-time counters (saturating)
LOCK_CYCLES, 4, consecutive good periods required to enter LOCKED
TOL, 1, allowed +/- deviation, in ref_clk cycles, for period and high time
TIMEOUT, 64, ref_clk cycles without a rising edge before a missing-edge fault (must be < 2^CNT_W)

Ports:
ref_clk  input  1  sole clock
rst  input  1  synchronous, active-high reset
mon_enable  input  1  enable monitoring; 0 forces IDLE
mon_clk_in  input  1  monitored clock, asynchronous to ref_clk
cfg_div_ratio  input  4  expected period in ref_clk cycles
mon_clear  input  1  single-cycle pulse; clears a sticky fault
clk_valid  output  1  monitor is active (state != IDLE)
clk_stable  output  1  state == LOCKED
period_meas  output  CNT_W  last latched period
high_meas  output  CNT_W  last latched high time
error_code  output  8  00 none, 01 missing edge, 02 period, 03 duty, 04 unmeasurable config
period_min  output  CNT_W  minimum period since clear (optional feature)
period_max  output  CNT_W  maximum period since clear (optional feature)

Behaviour:
- Single clock (ref_clk); reset is synchronous and active-high (rst).
- Reset values:
  - state IDLE; all outputs 0, except period_min = all-ones.
  - Internal counters and cfg copy 0.
- Input path: 2-flop synchronizer, then rising-edge detect (rise = s1 & ~s2). Latency from a mon_clk_in transition to rise is 2-3 cycles.
- Counters, at every cycle outside IDLE:
  - per_cnt increments, saturating at all-ones.
  - hi_cnt increments when s2 = 1, saturating.
  - On rise: period_meas <= per_cnt+1 (saturating), high_meas <= hi_cnt, then both counters restart at 0.
- Checks on each rise after the arming edge:
  - Period good: |period_meas - cfg| <= TOL.
  - Duty good: |high_meas - (cfg>>1)| <= TOL.
  - All checks use the values latched at that rise.
- cfg_div_ratio is registered into cfg_q. Any change of cfg_q while in ACQUIRE or LOCKED returns to ACQUIRE (disarmed, good count 0) with no fault.
- FSM states: IDLE, ACQUIRE, LOCKED, FAULT.
  - IDLE -> ACQUIRE when mon_enable = 1. The first rise in ACQUIRE only arms; it is a partial period and is not checked.
  - ACQUIRE:
    - Good rise: good_cnt++.
    - Bad rise: good_cnt = 0, no fault.
    - good_cnt reaching LOCK_CYCLES -> LOCKED in the cycle after that rise.
    - per_cnt == TIMEOUT -> FAULT, error_code 01.
  - LOCKED:
    - Bad period -> FAULT 02.
    - Bad duty (period good) -> FAULT 03.
    - Timeout -> FAULT 01.
    - Priority: 01 > 02 > 03.
  - FAULT: sticky; error_code held. mon_clear -> ACQUIRE with error_code 00.
  - cfg_q < 2: the clock is not measurable. Stay in ACQUIRE, error_code 04, clk_stable 0, no timeout. Clears to 00 once cfg_q >= 2.
- Precedence: mon_enable = 0 (-> IDLE, error_code 00) > mon_clear > fault detection in the same cycle.
- rst asserted mid-operation: every output returns to its reset value on the next edge.

Optional Feature:
- Macro CLK_RX_MON_JITTER_EN.
- Defined:
  - On each checked rise, period_min/period_max are updated with period_meas.
  - Both reset to all-ones/0 on rst, mon_clear, or entry to IDLE.
- Undefined: period_min and period_max are tied to 0 and there is no tracking logic.

Decomposition:
- Package clk_rx_mon_pkg: state enum (IDLE, ACQUIRE, LOCKED, FAULT) and error-code localparams (ERR_NONE, ERR_MISSING, ERR_PERIOD, ERR_DUTY, ERR_CFG).
- Sub-module clk_edge_sync: 2-flop synchronizer plus rising-edge pulse, with synchronous active-high reset.

Test Plan:
- Lock: cfg = 4, mon_enable = 1, mon_clk_in 2 high / 2 low continuously -> period_meas = 4, high_meas = 2; clk_stable rises the cycle after the 5th synchronized rise; error_code 00.
- Missing edge: lock as above, then hold mon_clk_in low -> FAULT with error_code 01 when per_cnt reaches 64; clk_stable 0.
- Period error: cfg = 4, locked, then 3 high / 3 low -> period_meas = 6, error_code 02. mon_clear -> ACQUIRE, error_code 00, relock after 5 good rises.
- Duty error: cfg = 8, locked at 4/4, then 7 high / 1 low -> period_meas = 8, high_meas = 7, error_code 03.
- Config and precedence:
  - cfg = 1 -> error_code 04 and no timeout.
  - Change cfg from 4 to 8 while locked -> ACQUIRE with no fault.
  - mon_clear and mon_enable = 0 in the same cycle -> IDLE.
  - rst mid-LOCKED -> all outputs 0 next cycle (period_min all-ones).
- Jitter (CLK_RX_MON_JITTER_EN defined): alternate periods 3, 5 with cfg = 4 -> period_min = 3, period_max = 5. Without the macro, both read 0.

Source files
------------

// File: rtl/clk_rx_monitor_pkg.sv
// Shared types for the clock receive monitor: FSM states, error codes and a
// small distance helper used by the period/duty checks.
package clk_rx_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } mon_state_e;

  localparam logic [7:0] ERR_NONE    = 8'h00;
  localparam logic [7:0] ERR_MISSING = 8'h01;
  localparam logic [7:0] ERR_PERIOD  = 8'h02;
  localparam logic [7:0] ERR_DUTY    = 8'h03;
  localparam logic [7:0] ERR_CFG     = 8'h04;

  function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/clk_edge_sync.sv
// Two-flop synchronizer for an asynchronous clock-as-data input, plus a delay
// flop giving a one-cycle rising-edge pulse and the delayed level.
module clk_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta_q, meta_d;
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    meta_d = async_in;
    s1_d   = meta_q;
    s2_d   = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
    end else begin
      meta_q <= meta_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
    end
  end

  assign rise  = s1_q & ~s2_q;
  assign level = s2_q;

endmodule

// File: rtl/clk_rx_monitor.sv
// Receive-side monitor for one distributed clock: measures period/high time in
// ref_clk cycles, runs lock/fault FSM. Define CLK_RX_MON_JITTER_EN for min/max tracking.
module clk_rx_monitor
  import clk_rx_mon_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 4,
  parameter int TOL         = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic             ref_clk,
  input  logic             rst,
  input  logic             mon_enable,
  input  logic             mon_clk_in,
  input  logic [3:0]       cfg_div_ratio,
  input  logic             mon_clear,
  output logic             clk_valid,
  output logic             clk_stable,
  output logic [CNT_W-1:0] period_meas,
  output logic [CNT_W-1:0] high_meas,
  output logic [7:0]       error_code,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max
);

  localparam int GC_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [GC_W-1:0]  LOCK_VAL = GC_W'(LOCK_CYCLES);

  mon_state_e       state_q, state_d;
  logic [3:0]       cfg_q, cfg_d;
  logic             armed_q, armed_d;
  logic [GC_W-1:0]  good_q, good_d;
  logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d;
  logic [CNT_W-1:0] pm_q, pm_d, hm_q, hm_d;
  logic [7:0]       err_q, err_d;

  logic             rise, lvl, restart;
  logic             cfg_chg, cfg_bad, per_to, per_ok, duty_ok;
  logic [CNT_W-1:0] per_inc, hi_inc;

  clk_edge_sync u_sync (
    .clk      (ref_clk),
    .rst      (rst),
    .async_in (mon_clk_in),
    .level    (lvl),
    .rise     (rise)
  );

  // Checks look at the values being latched on this rise, not the stale ones.
  assign per_inc = (per_q == CNT_MAX) ? per_q : per_q + 1'b1;
  assign hi_inc  = (hi_q  == CNT_MAX) ? hi_q  : hi_q  + 1'b1;
  assign cfg_chg = (cfg_div_ratio != cfg_q);
  assign cfg_bad = (cfg_q < 4'd2);
  assign per_to  = (per_q == TO_VAL);
  assign per_ok  = abs_diff(16'(per_inc), 16'(cfg_q)) <= 16'(TOL);
  assign duty_ok = abs_diff(16'(hi_q), 16'(cfg_q >> 1)) <= 16'(TOL);

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    good_d  = good_q;
    err_d   = err_q;
    restart = 1'b0;
    case (state_q)
      IDLE: if (mon_enable) restart = 1'b1;
      ACQUIRE: begin
        if (cfg_chg) restart = 1'b1;
        else if (cfg_bad) err_d = ERR_CFG;
        else if (per_to) begin
          state_d = FAULT;
          err_d   = ERR_MISSING;
        end else begin
          err_d = ERR_NONE;
          if (rise) begin
            if (!armed_q) armed_d = 1'b1;
            else if (per_ok && duty_ok) begin
              good_d = good_q + 1'b1;
              if (good_d == LOCK_VAL) state_d = LOCKED;
            end else good_d = '0;
          end
        end
      end
      LOCKED: begin
        if (cfg_chg) restart = 1'b1;
        else if (per_to) begin
          state_d = FAULT;
          err_d   = ERR_MISSING;
        end else if (rise && !per_ok) begin
          state_d = FAULT;
          err_d   = ERR_PERIOD;
        end else if (rise && !duty_ok) begin
          state_d = FAULT;
          err_d   = ERR_DUTY;
        end
      end
      FAULT: ;
      default: state_d = IDLE;
    endcase
    // A clear wins over a fault detected in the same cycle.
    if (mon_clear && (state_q == FAULT || state_d == FAULT)) begin
      restart = 1'b1;
      err_d   = ERR_NONE;
    end
    if (restart) begin
      state_d = ACQUIRE;
      armed_d = 1'b0;
      good_d  = '0;
    end
    if (!mon_enable) begin
      state_d = IDLE;
      err_d   = ERR_NONE;
      armed_d = 1'b0;
      good_d  = '0;
    end
  end

  always_comb begin
    cfg_d = cfg_div_ratio;
    per_d = per_inc;
    hi_d  = lvl ? hi_inc : hi_q;
    pm_d  = pm_q;
    hm_d  = hm_q;
    if (rise && state_q != IDLE) begin
      pm_d  = per_inc;
      hm_d  = hi_q;
      per_d = '0;
      hi_d  = '0;
    end
    // Restarting acquisition also restarts the missing-edge window.
    if (state_q == IDLE || restart) begin
      per_d = '0;
      hi_d  = '0;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      armed_q <= 1'b0;
      good_q  <= '0;
      per_q   <= '0;
      hi_q    <= '0;
      pm_q    <= '0;
      hm_q    <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      armed_q <= armed_d;
      good_q  <= good_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      pm_q    <= pm_d;
      hm_q    <= hm_d;
      err_q   <= err_d;
    end
  end

`ifdef CLK_RX_MON_JITTER_EN
  logic [CNT_W-1:0] pmin_q, pmin_d, pmax_q, pmax_d;
  logic             chk_rise;

  assign chk_rise = rise && armed_q && (state_q == ACQUIRE || state_q == LOCKED);

  always_comb begin
    pmin_d = pmin_q;
    pmax_d = pmax_q;
    if (chk_rise) begin
      if (per_inc < pmin_q) pmin_d = per_inc;
      if (per_inc > pmax_q) pmax_d = per_inc;
    end
    if (mon_clear || (state_d == IDLE && state_q != IDLE)) begin
      pmin_d = '1;
      pmax_d = '0;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      pmin_q <= '1;
      pmax_q <= '0;
    end else begin
      pmin_q <= pmin_d;
      pmax_q <= pmax_d;
    end
  end

  assign period_min = pmin_q;
  assign period_max = pmax_q;
`else
  assign period_min = '0;
  assign period_max = '0;
`endif

  assign clk_valid   = (state_q != IDLE);
  assign clk_stable  = (state_q == LOCKED);
  assign period_meas = pm_q;
  assign high_meas   = hm_q;
  assign error_code  = err_q;

endmodule

// File: tb/tb_clk_rx_monitor.sv
// Directed bench for clk_rx_monitor: lock, missing edge, period/duty faults,
// config handling, precedence, reset and optional min/max tracking.
module tb_clk_rx_monitor;

`ifdef CLK_RX_MON_JITTER_EN
  localparam bit JIT = 1'b1;
`else
  localparam bit JIT = 1'b0;
`endif

  logic       ref_clk = 1'b0;
  logic       rst = 1'b1;
  logic       mon_enable = 1'b0;
  logic       mon_clk_in;
  logic [3:0] cfg_div_ratio = 4'd4;
  logic       mon_clear = 1'b0;
  logic       clk_valid, clk_stable;
  logic [7:0] period_meas, high_meas, error_code, period_min, period_max;

  int n_chk = 0;
  int n_fail = 0;

  // monitored clock generator state
  int cyc = 0, gen_rises = 0, gen_rise_cyc = 0, ph = 0;
  int hi_a = 2, lo_a = 2, hi_b = 2, lo_b = 2, cur_hi = 2, cur_lo = 2;
  bit gen_en = 1'b0, alt = 1'b0, sel = 1'b0;
  int base, t_fault;

  clk_rx_monitor dut (
    .ref_clk       (ref_clk),
    .rst           (rst),
    .mon_enable    (mon_enable),
    .mon_clk_in    (mon_clk_in),
    .cfg_div_ratio (cfg_div_ratio),
    .mon_clear     (mon_clear),
    .clk_valid     (clk_valid),
    .clk_stable    (clk_stable),
    .period_meas   (period_meas),
    .high_meas     (high_meas),
    .error_code    (error_code),
    .period_min    (period_min),
    .period_max    (period_max)
  );

  always #5 ref_clk = ~ref_clk;

  // New high/low lengths take effect only at a period boundary.
  initial begin
    mon_clk_in = 1'b0;
    forever begin
      @(negedge ref_clk);
      cyc++;
      if (!gen_en) begin
        mon_clk_in = 1'b0;
        ph = 0;
        sel = 1'b0;
      end else begin
        if (ph == 0) begin
          cur_hi = sel ? hi_b : hi_a;
          cur_lo = sel ? lo_b : lo_a;
          sel = alt ? ~sel : 1'b0;
          gen_rises++;
          gen_rise_cyc = cyc;
        end
        mon_clk_in = (ph < cur_hi);
        ph = (ph + 1 >= cur_hi + cur_lo) ? 0 : ph + 1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge ref_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic wait_stable(input string tag, input int budget);
    int k;
    k = 0;
    while (clk_stable !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, {31'b0, clk_stable}, 32'd1);
  endtask

  task automatic wait_err(input string tag, input int budget);
    int k;
    k = 0;
    while (error_code === 8'h00 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, {31'b0, (error_code !== 8'h00)}, 32'd1);
  endtask

  task automatic do_reset(input logic [3:0] cfg);
    rst = 1'b1;
    mon_enable = 1'b0;
    mon_clear = 1'b0;
    gen_en = 1'b0;
    alt = 1'b0;
    hi_a = 2; lo_a = 2; hi_b = 2; lo_b = 2;
    cfg_div_ratio = cfg;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic start_lock(input string tag, input int budget);
    mon_enable = 1'b1;
    gen_en = 1'b1;
    wait_stable(tag, budget);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, {31'b0, clk_valid}, 32'd0);
    chk({tag, "_stable"}, {31'b0, clk_stable}, 32'd0);
    chk({tag, "_per"}, period_meas, 32'd0);
    chk({tag, "_hi"}, high_meas, 32'd0);
    chk({tag, "_err"}, error_code, 32'd0);
    chk({tag, "_pmin"}, period_min, JIT ? 32'hFF : 32'h0);
    chk({tag, "_pmax"}, period_max, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, sampled while rst is still asserted
    tick(3);
    chk_reset_outs("rst0");
    rst = 1'b0;
    tick(1);

    // lock at cfg 4 with 2/2: arming rise + 4 good rises
    base = gen_rises;
    start_lock("lock", 40);
    chk("lock_rises", gen_rises - base, 32'd5);
    chk("lock_per", period_meas, 32'd4);
    chk("lock_hi", high_meas, 32'd2);
    chk("lock_err", error_code, 32'd0);
    chk("lock_valid", {31'b0, clk_valid}, 32'd1);

    // missing edge: fault 68 cycles after the last generated rise
    gen_en = 1'b0;
    wait_err("miss_wait", 100);
    t_fault = cyc;
    chk("miss_lat", t_fault - gen_rise_cyc, 32'd68);
    chk("miss_err", error_code, 32'h01);
    chk("miss_stable", {31'b0, clk_stable}, 32'd0);
    chk("miss_valid", {31'b0, clk_valid}, 32'd1);

    // clear and disable together: disable wins
    mon_clear = 1'b1;
    mon_enable = 1'b0;
    tick(1);
    mon_clear = 1'b0;
    chk("clrdis_valid", {31'b0, clk_valid}, 32'd0);
    chk("clrdis_err", error_code, 32'd0);

    // period fault, sticky, clear, relock
    do_reset(4'd4);
    start_lock("per_lock", 40);
    hi_a = 3; lo_a = 3;
    wait_err("per_wait", 40);
    chk("per_err", error_code, 32'h02);
    chk("per_meas", period_meas, 32'd6);
    chk("per_stable", {31'b0, clk_stable}, 32'd0);
    hi_a = 2; lo_a = 2;
    tick(20);
    chk("per_sticky", error_code, 32'h02);
    mon_clear = 1'b1;
    tick(1);
    mon_clear = 1'b0;
    chk("per_clr_err", error_code, 32'd0);
    chk("per_clr_valid", {31'b0, clk_valid}, 32'd1);
    chk("per_clr_stable", {31'b0, clk_stable}, 32'd0);
    wait_stable("per_relock", 40);
    chk("per_relock_meas", period_meas, 32'd4);

    // duty fault at cfg 8: 7 high / 1 low
    do_reset(4'd8);
    hi_a = 4; lo_a = 4;
    start_lock("duty_lock", 60);
    hi_a = 7; lo_a = 1;
    wait_err("duty_wait", 40);
    chk("duty_err", error_code, 32'h03);
    chk("duty_per", period_meas, 32'd8);
    chk("duty_hi", high_meas, 32'd7);

    // cfg change while locked: back to acquire, never a fault
    do_reset(4'd4);
    start_lock("cfgchg_lock", 40);
    cfg_div_ratio = 4'd8;
    tick(2);
    chk("cfgchg_stable", {31'b0, clk_stable}, 32'd0);
    chk("cfgchg_valid", {31'b0, clk_valid}, 32'd1);
    chk("cfgchg_err", error_code, 32'd0);
    tick(30);
    chk("cfgchg_nofault", error_code, 32'd0);

    // unmeasurable cfg: code 04, no timeout; clears when cfg becomes valid
    do_reset(4'd1);
    mon_enable = 1'b1;
    tick(3);
    chk("cfg1_err", error_code, 32'h04);
    chk("cfg1_valid", {31'b0, clk_valid}, 32'd1);
    tick(100);
    chk("cfg1_noto", error_code, 32'h04);
    chk("cfg1_stable", {31'b0, clk_stable}, 32'd0);
    cfg_div_ratio = 4'd4;
    tick(3);
    chk("cfg1_clr", error_code, 32'd0);
    wait_err("cfg4_to_wait", 100);
    chk("cfg4_to", error_code, 32'h01);

    // reset asserted while locked
    do_reset(4'd4);
    start_lock("rstl_lock", 40);
    rst = 1'b1;
    tick(1);
    chk_reset_outs("rstl");
    rst = 1'b0;

    // alternating 3/5 periods around cfg 4
    do_reset(4'd4);
    hi_a = 1; lo_a = 2; hi_b = 2; lo_b = 3; alt = 1'b1;
    start_lock("jit_lock", 60);
    chk("jit_min", period_min, JIT ? 32'd3 : 32'd0);
    chk("jit_max", period_max, JIT ? 32'd5 : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
